// File: rtl/mm_block_responder_pkg.sv
// Shared types and constants for the main-memory block responder.
// Block address = word address without its 2-bit in-block offset.
package mm_pkg;
  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int OFF_W       = 2;
  localparam int BLK_W       = ADDR_W - OFF_W;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [BLK_W-1:0]  blk_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef word_t [BLOCK_WORDS-1:0] block_t;

  function automatic blk_t blk_of(addr_t a);
    return a[ADDR_W-1:OFF_W];
  endfunction
endpackage

// File: rtl/mm_block_responder_if.sv
// Cache <-> main-memory bus: block fetch handshake,
// 4-word response and single-word write port.
interface mm_block_responder_if;
  import mm_pkg::*;

  logic  req_valid;
  logic  req_ready;
  addr_t req_addr;
  logic  resp_valid;
  logic  resp_ready;
  word_t blk_word0;
  word_t blk_word1;
  word_t blk_word2;
  word_t blk_word3;
  logic  wr_en;
  addr_t wr_addr;
  word_t wr_data;

  modport master (
    output req_valid, req_addr, resp_ready,
    output wr_en, wr_addr, wr_data,
    input  req_ready, resp_valid,
    input  blk_word0, blk_word1, blk_word2, blk_word3
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    input  wr_en, wr_addr, wr_data,
    output req_ready, resp_valid,
    output blk_word0, blk_word1, blk_word2, blk_word3
  );
endinterface

// File: rtl/mm_block_responder_array.sv
// Word storage split into one bank per block offset so a whole
// aligned block reads in one cycle; single write port.
module mm_block_array
  import mm_pkg::*;
(
  input  logic   clk,
  input  logic   wr_en,
  input  addr_t  wr_addr,
  input  word_t  wr_data,
  input  blk_t   rd_blk,
  output block_t rd_words
);

  for (genvar k = 0; k < BLOCK_WORDS; k++) begin : g_bank
    word_t mem [2**BLK_W];

    always_ff @(posedge clk) begin
      if (wr_en && wr_addr[OFF_W-1:0] == OFF_W'(k))
        mem[blk_of(wr_addr)] <= wr_data;
    end

    assign rd_words[k] = mem[rd_blk];
  end

endmodule

// File: rtl/mm_block_responder.sv
// Block fetch responder: IDLE/WAIT/RESP FSM with fixed latency.
// Optional MM_BLOCK_BYPASS_EN adds a one-entry last-block buffer.
module mm_block_responder
  import mm_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input logic clk,
  input logic rst,
  mm_block_responder_if.slave bus
);

  state_t     state;
  state_t     state_nx;
  logic [CNT_W-1:0] cnt;
  blk_t       blk;
  block_t     words;
  block_t     rd_words;
  logic       accept;
  logic       capture;
  block_t     cap_words;
  logic       unused_ok;

  assign accept    = bus.req_valid & bus.req_ready;
  assign capture   = (state == WAIT) && (cnt == '0);
  assign unused_ok = ^bus.req_addr[OFF_W-1:0];

  mm_block_array u_array (
    .clk      (clk),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_blk   (blk),
    .rd_words (rd_words)
  );

`ifdef MM_BLOCK_BYPASS_EN
  logic   buf_valid;
  blk_t   buf_blk;
  block_t buf_data;
  logic   wr_hit_buf;
  logic   hit;
  logic   byp;

  assign wr_hit_buf = bus.wr_en && (blk_of(bus.wr_addr) == buf_blk);
  assign hit = buf_valid && !wr_hit_buf
            && (blk_of(bus.req_addr) == buf_blk);
  assign cap_words = byp ? buf_data : rd_words;

  // A same-edge write into the captured block makes the copy stale
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_blk   <= '0;
      buf_data  <= '0;
      byp       <= 1'b0;
    end else begin
      if (accept) byp <= hit;
      if (wr_hit_buf) buf_valid <= 1'b0;
      if (capture) begin
        buf_blk   <= blk;
        buf_data  <= cap_words;
        buf_valid <= !(bus.wr_en && blk_of(bus.wr_addr) == blk);
      end
    end
  end
`else
  logic hit;
  assign hit       = 1'b0;
  assign cap_words = rd_words;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    if (bus.resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = rst && (state == IDLE);
    bus.resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      blk   <= '0;
      words <= '0;
    end else begin
      if (accept) begin
        blk <= blk_of(bus.req_addr);
        cnt <= hit ? '0 : CNT_W'(LATENCY - 1);
      end
      if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (capture) words <= cap_words;
    end
  end

  assign bus.blk_word0 = words[0];
  assign bus.blk_word1 = words[1];
  assign bus.blk_word2 = words[2];
  assign bus.blk_word3 = words[3];

endmodule
